// File: rtl/axis_bram_line_reader_if.sv
// AXI-Stream bundle carrying the serialized words of a BRAM line.
//
// Signals:
//   tdata  - stream word, WORD_WIDTH bits
//   tvalid - word is presented
//   tready - consumer accepts the word
//   tlast  - final word of the final line in a transfer
//
// The master modport is for the producer (the line reader) and the
// slave modport is for the downstream consumer.
interface axis_bram_line_reader_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_bram_line_reader.sv
// Reads wide BRAM lines over an inclusive, wrapping address range and
// serializes each line into WORDS_PER_LINE AXI-Stream words with full
// tvalid/tready backpressure. Word 0 of a line is its most significant slice.
//
// Ports:
//   clk               - clock, rising edge
//   rstn              - asynchronous active-low reset
//   start_i           - one-cycle pulse, accepted only while idle
//   bramStartIndex_i  - first line address, sampled on an accepted start
//   bramBoundIndex_i  - last line address, sampled on an accepted start
//   busy_o            - transfer in progress (through the done cycle)
//   done_o            - one-cycle pulse after the last word is accepted
//   bramEn_o          - BRAM read enable (one cycle per line)
//   bramIndex_o       - BRAM line address
//   bramRdata_i       - BRAM read data, valid one cycle after bramEn_o
//   mAxis             - AXI-Stream master bundle
//   cnt_o             - word index within the current line
module axis_bram_line_reader #(
    parameter int BRAM_ADDR_LENGTH = 12,
    parameter int WORD_WIDTH       = 16,
    parameter int WORDS_PER_LINE   = 36,
    parameter int CNT_BITS         = 6
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start_i,
    input  logic [BRAM_ADDR_LENGTH-1:0]          bramStartIndex_i,
    input  logic [BRAM_ADDR_LENGTH-1:0]          bramBoundIndex_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 bramEn_o,
    output logic [BRAM_ADDR_LENGTH-1:0]          bramIndex_o,
    input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bramRdata_i,
    axis_bram_line_reader_if.master              mAxis,
    output logic [CNT_BITS-1:0]                  cnt_o
);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        STREAM,
        DONE
    } state_t;

    state_t                                      state_q;
    logic [BRAM_ADDR_LENGTH-1:0]                 bound_q;
    logic [BRAM_ADDR_LENGTH-1:0]                 bramIndex_q;
    logic [BRAM_ADDR_LENGTH-1:0]                 bramIndex_d;
    logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0]   lineBuf_q;
    logic [CNT_BITS-1:0]                         cnt_q;
    logic [CNT_BITS-1:0]                         wordIdx;
    logic                                        bramEn_q;
    logic                                        busy_q;
    logic                                        done_q;
    logic                                        tvalid_q;

    // Next line address; plain truncating add gives the wrap through the
    // all-ones address back to zero when the bound lies below the start.
    assign bramIndex_d = bramIndex_q + 1'b1;

    // Word k lives in packed element WORDS_PER_LINE-1-k, so word 0 is the
    // most significant slice of the captured line.
    assign wordIdx = LAST_CNT - cnt_q;

    // Single sequencer: every output except tdata/tlast is a register
    // updated here, so the stream outputs stay frozen for as long as the
    // consumer holds tready low in STREAM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bound_q     <= '0;
            bramIndex_q <= '0;
            lineBuf_q   <= '0;
            cnt_q       <= '0;
            bramEn_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bound_q     <= bramBoundIndex_i;
                        bramIndex_q <= bramStartIndex_i;
                        bramEn_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= RD;
                    end
                end
                RD: begin
                    bramEn_q <= 1'b0;
                    state_q  <= CAP;
                end
                CAP: begin
                    // Read latency is one cycle, so the line is on the bus now.
                    lineBuf_q <= bramRdata_i;
                    cnt_q     <= '0;
                    tvalid_q  <= 1'b1;
                    state_q   <= STREAM;
                end
                STREAM: begin
                    if (mAxis.tready) begin
                        if (cnt_q == LAST_CNT) begin
                            tvalid_q <= 1'b0;
                            cnt_q    <= '0;
                            if (bramIndex_q == bound_q) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                bramIndex_q <= bramIndex_d;
                                bramEn_q    <= 1'b1;
                                state_q     <= RD;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mAxis.tvalid = tvalid_q;
    assign mAxis.tdata  = lineBuf_q[wordIdx];
    assign mAxis.tlast  = (state_q == STREAM) && (cnt_q == LAST_CNT) &&
                          (bramIndex_q == bound_q);

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign bramEn_o    = bramEn_q;
    assign bramIndex_o = bramIndex_q;
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_axis_bram_line_reader.sv
// Self-checking bench for axis_bram_line_reader: a table of transfers
// (range, ready pattern, expected line count and done latency) plus
// hand-written sequences for stalls, ignored restarts and mid-stream reset.
module tb_axis_bram_line_reader;

    localparam int AW  = 12;
    localparam int WW  = 16;
    localparam int WPL = 36;
    localparam int CB  = 6;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     startIdx = '0;
    logic [AW-1:0]     boundIdx = '0;
    logic              busy;
    logic              done;
    logic              bramEn;
    logic [AW-1:0]     bramIndex;
    logic [WW*WPL-1:0] bramRdata = '0;
    logic [CB-1:0]     cnt;

    axis_bram_line_reader_if #(.WORD_WIDTH(WW)) axisIf ();

    axis_bram_line_reader #(
        .BRAM_ADDR_LENGTH (AW),
        .WORD_WIDTH       (WW),
        .WORDS_PER_LINE   (WPL),
        .CNT_BITS         (CB)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start_i          (start),
        .bramStartIndex_i (startIdx),
        .bramBoundIndex_i (boundIdx),
        .busy_o           (busy),
        .done_o           (done),
        .bramEn_o         (bramEn),
        .bramIndex_o      (bramIndex),
        .bramRdata_i      (bramRdata),
        .mAxis            (axisIf),
        .cnt_o            (cnt)
    );

    always #5 clk = ~clk;

    // Word k of line addr; the xor makes line 5 carry the plain values 0..35.
    function automatic logic [WW-1:0] modelWord(input logic [AW-1:0] addr, input int k);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = addr[7:0] ^ 8'h05;
        lo = 8'(k);
        return {hi, lo};
    endfunction

    // Line image with word 0 in the most significant slice.
    function automatic logic [WW*WPL-1:0] makeLine(input logic [AW-1:0] addr);
        logic [WW*WPL-1:0] line;
        line = '0;
        for (int k = 0; k < WPL; k++) begin
            line[WW*(WPL-k)-1 -: WW] = modelWord(addr, k);
        end
        return line;
    endfunction

    // BRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bramEn) bramRdata <= makeLine(bramIndex);
    end

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: tready always high, 1: random 50%, 2: tready held low.
    int readyMode = 0;
    initial begin
        axisIf.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       axisIf.tready = 1'b1;
                1:       axisIf.tready = 1'($urandom_range(0, 1));
                default: axisIf.tready = 1'b0;
            endcase
        end
    end

    logic [WW-1:0] wordQ[$];
    bit            lastQ[$];
    logic [AW-1:0] addrQ[$];
    int            doneCount = 0;
    int            startCyc = 0;
    int            firstEnCyc = -1;
    int            firstValidCyc = -1;
    int            busyCyc = -1;
    int            doneCyc = -1;
    bit            prevStall = 1'b0;
    logic [WW-1:0] prevData = '0;
    logic          prevLast = 1'b0;

    // Mid-cycle monitor: records transfers/reads and enforces AXIS hold rules.
    always @(negedge clk) begin
        if (!rstn) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("holdValid", axisIf.tvalid, 1);
                checkOutput("holdData", axisIf.tdata, prevData);
                checkOutput("holdLast", axisIf.tlast, prevLast);
                checkOutput("stallNoBram", bramEn, 0);
            end
            if (axisIf.tvalid && axisIf.tready) begin
                wordQ.push_back(axisIf.tdata);
                lastQ.push_back(axisIf.tlast);
            end
            if (bramEn) begin
                addrQ.push_back(bramIndex);
                if (firstEnCyc < 0) firstEnCyc = cyc;
            end
            if (axisIf.tvalid && firstValidCyc < 0) firstValidCyc = cyc;
            if (busy && busyCyc < 0) busyCyc = cyc;
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
            prevStall = axisIf.tvalid && !axisIf.tready;
            prevData  = axisIf.tdata;
            prevLast  = axisIf.tlast;
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] b);
        wordQ.delete();
        lastQ.delete();
        addrQ.delete();
        doneCount     = 0;
        firstEnCyc    = -1;
        firstValidCyc = -1;
        busyCyc       = -1;
        doneCyc       = -1;
        @(posedge clk);
        #1;
        startIdx = s;
        boundIdx = b;
        start    = 1'b1;
        startCyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("doneSeen", seen, 1);
        if (seen) begin
            @(negedge clk);
            checkOutput("busyAfterDone", busy, 0);
            checkOutput("donePulseWidth", done, 0);
        end
    endtask

    task automatic checkScoreboard(input logic [AW-1:0] s, input logic [AW-1:0] b,
                                   input int expLines);
        logic [AW-1:0] expAddr[$];
        logic [AW-1:0] a;
        int            total;
        a = s;
        for (int guard = 0; guard < (1 << AW); guard++) begin
            expAddr.push_back(a);
            if (a == b) break;
            a = a + 1'b1;
        end
        total = expAddr.size() * WPL;
        checkOutput("lineCount", addrQ.size(), expLines);
        for (int i = 0; i < expAddr.size() && i < addrQ.size(); i++) begin
            checkOutput("lineAddr", addrQ[i], expAddr[i]);
        end
        checkOutput("wordCount", wordQ.size(), total);
        for (int i = 0; i < wordQ.size() && i < total; i++) begin
            checkOutput("word", wordQ[i], modelWord(expAddr[i / WPL], i % WPL));
            checkOutput("tlast", lastQ[i], (i == total - 1) ? 1 : 0);
        end
        checkOutput("donePulses", doneCount, 1);
    endtask

    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] b;
        int            mode;
        int            lines;
        int            doneRel;
    } vec_t;

    vec_t vecs[5];

    task automatic checkTiming(input int doneRel);
        checkOutput("enLatency", firstEnCyc - startCyc, 1);
        checkOutput("busyLatency", busyCyc - startCyc, 1);
        checkOutput("validLatency", firstValidCyc - startCyc, 3);
        checkOutput("doneLatency", doneCyc - startCyc, doneRel);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;

        // Done latency per line is RD + CAP + 36 words, plus one for done.
        vecs[0] = '{s: 12'd5,    b: 12'd5,    mode: 0, lines: 1, doneRel: 39};
        vecs[1] = '{s: 12'd10,   b: 12'd12,   mode: 0, lines: 3, doneRel: 115};
        vecs[2] = '{s: 12'd40,   b: 12'd42,   mode: 1, lines: 3, doneRel: 0};
        vecs[3] = '{s: 12'd4094, b: 12'd1,    mode: 0, lines: 4, doneRel: 153};
        vecs[4] = '{s: 12'd4095, b: 12'd4095, mode: 1, lines: 1, doneRel: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstValid", axisIf.tvalid, 0);
        checkOutput("rstTlast", axisIf.tlast, 0);
        checkOutput("rstTdata", axisIf.tdata, 0);
        checkOutput("rstBramEn", bramEn, 0);
        checkOutput("rstIndex", bramIndex, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstCnt", cnt, 0);
        rstn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %0d: start=%0d bound=%0d mode=%0d", v, vecs[v].s, vecs[v].b, vecs[v].mode);
            readyMode = vecs[v].mode;
            applyStimulus(vecs[v].s, vecs[v].b);
            waitDone(4000);
            checkScoreboard(vecs[v].s, vecs[v].b, vecs[v].lines);
            if (vecs[v].doneRel > 0) checkTiming(vecs[v].doneRel);
        end

        // tready held low: outputs frozen on word 0, no BRAM traffic.
        $display("[TB] sequence: long stall");
        readyMode = 2;
        applyStimulus(12'd7, 12'd7);
        repeat (25) @(negedge clk);
        checkOutput("stallValid", axisIf.tvalid, 1);
        checkOutput("stallCnt", cnt, 0);
        checkOutput("stallData", axisIf.tdata, modelWord(12'd7, 0));
        checkOutput("stallBramEn", bramEn, 0);
        checkOutput("stallBusy", busy, 1);
        readyMode = 0;
        waitDone(200);
        checkScoreboard(12'd7, 12'd7, 1);

        // Restart pulse and index changes mid-transfer are ignored.
        $display("[TB] sequence: ignored restart");
        readyMode = 0;
        applyStimulus(12'd20, 12'd21);
        repeat (10) @(posedge clk);
        #1;
        startIdx = 12'd100;
        boundIdx = 12'd200;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        startIdx = 12'd300;
        boundIdx = 12'd301;
        waitDone(400);
        checkScoreboard(12'd20, 12'd21, 2);

        // Reset during word 17, then a clean run with normal timing.
        $display("[TB] sequence: reset mid-stream");
        applyStimulus(12'd30, 12'd30);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (axisIf.tvalid && cnt == 6'd17) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reachWord17", found, 1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("midRstValid", axisIf.tvalid, 0);
        checkOutput("midRstBramEn", bramEn, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstCnt", cnt, 0);
        checkOutput("midRstIndex", bramIndex, 0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("midRstDone", done, 0);
        end
        rstn = 1'b1;
        checkOutput("noDoneAfterRst", doneCount, 0);
        applyStimulus(vecs[0].s, vecs[0].b);
        waitDone(200);
        checkScoreboard(vecs[0].s, vecs[0].b, vecs[0].lines);
        checkTiming(vecs[0].doneRel);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
